// File: rtl/tl_axi_host_arbiter.sv
// Round-robin arbiter sharing one TL-to-AXI bridge among several TileLink hosts.
// A channel is granted per message (whole Put bursts); D channel is routed by source idx.
module tl_axi_host_arbiter #(
    parameter int NumHosts    = 2,
    parameter int SourceWidth = 1,
    parameter int AddrWidth   = 56,
    parameter int DataWidth   = 64,
    parameter int SizeWidth   = 3,
    localparam int MaskWidth  = DataWidth / 8,
    localparam int IdxW       = $clog2(NumHosts),
    localparam int APW        = 6 + SizeWidth + SourceWidth + AddrWidth + MaskWidth + DataWidth,
    localparam int DPW        = 9 + SizeWidth + SourceWidth + DataWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumHosts-1:0]           host_a_valid_i,
    output logic [NumHosts-1:0]           host_a_ready_o,
    input  logic [NumHosts-1:0][APW-1:0]  host_a_i,
    output logic                          dev_a_valid_o,
    input  logic                          dev_a_ready_i,
    output logic [APW+IdxW-1:0]           dev_a_o,
    input  logic                          dev_d_valid_i,
    output logic                          dev_d_ready_o,
    input  logic [DPW+IdxW-1:0]           dev_d_i,
    output logic [NumHosts-1:0]           host_d_valid_o,
    input  logic [NumHosts-1:0]           host_d_ready_i,
    output logic [DPW-1:0]                host_d_o
);

    localparam int LgBytes = $clog2(MaskWidth);
    localparam int AL      = AddrWidth + MaskWidth + DataWidth;
    localparam int DL      = 3 + DataWidth;
    localparam int HiW     = 6 + SizeWidth;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        BURST
    } state_e;

    state_e                 state, state_nxt;
    logic [IdxW-1:0]        rr_ptr, rr_nxt;
    logic [IdxW-1:0]        owner, owner_nxt;
    logic [IdxW-1:0]        sel, sel_inc, didx;
    logic [7:0]             beat_cnt, cnt_nxt, beats_m1;
    logic [APW-1:0]         pay;
    logic [2:0]             opcode;
    logic [SizeWidth-1:0]   size, shamt;
    logic                   any_valid, hs, single;

    // Scan downward so the host closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        int j;
        sel       = rr_ptr;
        any_valid = 1'b0;
        for (int i = NumHosts - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= NumHosts) j = j - NumHosts;
            if (host_a_valid_i[j]) begin
                sel       = IdxW'(j);
                any_valid = 1'b1;
            end
        end
        if (state != IDLE) begin
            sel       = owner;
            any_valid = host_a_valid_i[owner];
        end
    end

    assign pay           = host_a_i[sel];
    assign dev_a_valid_o = any_valid;
    assign dev_a_o       = {pay[AL+SourceWidth +: HiW], sel, pay[AL +: SourceWidth], pay[AL-1:0]};
    assign hs            = any_valid & dev_a_ready_i;

    always_comb begin
        host_a_ready_o = '0;
        for (int i = 0; i < NumHosts; i++) begin
            if (sel == IdxW'(i) && (state != IDLE || any_valid)) begin
                host_a_ready_o[i] = dev_a_ready_i;
            end
        end
    end

    assign opcode   = pay[APW-1 -: 3];
    assign size     = pay[AL+SourceWidth +: SizeWidth];
    assign shamt    = size - SizeWidth'(LgBytes);
    assign single   = (opcode > 3'd1) || (int'(size) <= LgBytes);
    assign beats_m1 = (8'd1 << shamt) - 8'd1;
    assign sel_inc  = (sel == IdxW'(NumHosts - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        cnt_nxt   = beat_cnt;
        unique case (state)
            IDLE, HOLD: begin
                if (hs) begin
                    if (single) begin
                        state_nxt = IDLE;
                        rr_nxt    = sel_inc;
                    end else begin
                        state_nxt = BURST;
                        owner_nxt = sel;
                        cnt_nxt   = beats_m1;
                    end
                end else if (state == IDLE && any_valid) begin
                    state_nxt = HOLD;
                    owner_nxt = sel;
                end
            end
            BURST: begin
                if (hs) begin
                    if (beat_cnt <= 8'd1) begin
                        state_nxt = IDLE;
                        rr_nxt    = sel_inc;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = beat_cnt - 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            owner    <= owner_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

    // Responses route purely on the source idx bits; unknown idx beats are sunk.
    assign didx     = dev_d_i[DL+SourceWidth +: IdxW];
    assign host_d_o = {dev_d_i[DL+SourceWidth+IdxW +: HiW], dev_d_i[DL +: SourceWidth], dev_d_i[DL-1:0]};

    always_comb begin
        host_d_valid_o = '0;
        dev_d_ready_o  = 1'b1;
        if (int'(didx) < NumHosts) begin
            host_d_valid_o[didx] = dev_d_valid_i;
            dev_d_ready_o        = host_d_ready_i[didx];
        end
    end

endmodule

// File: tb/tb_tl_axi_host_arbiter.sv
// Directed bench for tl_axi_host_arbiter: round robin, bursts, hold, D routing, reset.
// A second three-host instance exercises out-of-range D source idx.
module tb_tl_axi_host_arbiter;

    localparam int APW = 138;
    localparam int DPW = 77;

    logic                   clk = 1'b0;
    logic                   rst_ni = 1'b0;
    logic [1:0]             host_a_valid = '0;
    logic [1:0]             host_a_ready;
    logic [1:0][APW-1:0]    host_a = '0;
    logic                   dev_a_valid;
    logic                   dev_a_ready = 1'b0;
    logic [APW:0]           dev_a;
    logic                   dev_d_valid = 1'b0;
    logic                   dev_d_ready;
    logic [DPW:0]           dev_d = '0;
    logic [1:0]             host_d_valid;
    logic [1:0]             host_d_ready = '0;
    logic [DPW-1:0]         host_d;

    logic [2:0]             h3_a_ready;
    logic                   d3_a_valid;
    logic [APW+1:0]         d3_a;
    logic                   d3_d_valid = 1'b0;
    logic                   d3_d_ready;
    logic [DPW+1:0]         d3_d = '0;
    logic [2:0]             h3_d_valid;
    logic [2:0]             h3_d_ready = '0;
    logic [DPW-1:0]         h3_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tl_axi_host_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .host_a_valid_i(host_a_valid), .host_a_ready_o(host_a_ready), .host_a_i(host_a),
        .dev_a_valid_o(dev_a_valid), .dev_a_ready_i(dev_a_ready), .dev_a_o(dev_a),
        .dev_d_valid_i(dev_d_valid), .dev_d_ready_o(dev_d_ready), .dev_d_i(dev_d),
        .host_d_valid_o(host_d_valid), .host_d_ready_i(host_d_ready), .host_d_o(host_d)
    );

    tl_axi_host_arbiter #(.NumHosts(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_ni),
        .host_a_valid_i(3'b000), .host_a_ready_o(h3_a_ready), .host_a_i('0),
        .dev_a_valid_o(d3_a_valid), .dev_a_ready_i(1'b0), .dev_a_o(d3_a),
        .dev_d_valid_i(d3_d_valid), .dev_d_ready_o(d3_d_ready), .dev_d_i(d3_d),
        .host_d_valid_o(h3_d_valid), .host_d_ready_i(h3_d_ready), .host_d_o(h3_d)
    );

    function automatic logic [APW-1:0] mk_a(input logic [2:0] op, input logic [2:0] sz,
                                            input logic src, input logic [55:0] addr,
                                            input logic [63:0] data);
        return {op, 3'b000, sz, src, addr, 8'hFF, data};
    endfunction

    function automatic logic [APW:0] mk_dev(input logic idx, input logic [2:0] op,
                                            input logic [2:0] sz, input logic src,
                                            input logic [55:0] addr, input logic [63:0] data);
        return {op, 3'b000, sz, idx, src, addr, 8'hFF, data};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        host_d_ready = 2'b01;
        #2;
        checks++;
        if (dev_a_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dev_a_valid got %b want 0", dev_a_valid);
        end
        checks++;
        if (host_a_ready !== 2'b00) begin
            errors++; $display("FAIL reset_host_a_ready got %b want 00", host_a_ready);
        end
        checks++;
        if (host_d_valid !== 2'b00) begin
            errors++; $display("FAIL reset_host_d_valid got %b want 00", host_d_valid);
        end
        checks++;
        if (dev_d_ready !== 1'b1) begin
            errors++; $display("FAIL reset_dev_d_ready1 got %b want 1", dev_d_ready);
        end
        host_d_ready = 2'b10;
        #1;
        checks++;
        if (dev_d_ready !== 1'b0) begin
            errors++; $display("FAIL reset_dev_d_ready0 got %b want 0", dev_d_ready);
        end
        host_d_ready = 2'b00;
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_round_robin;
        logic [1:0] want_rdy;
        int         h;
        host_a[0] = mk_a(3'd4, 3'd3, 1'b0, 56'h100, 64'h0);
        host_a[1] = mk_a(3'd4, 3'd3, 1'b1, 56'h200, 64'h0);
        host_a_valid = 2'b11;
        dev_a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            h = i % 2;
            want_rdy = (h == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (host_a_ready !== want_rdy) begin
                errors++; $display("FAIL rr_ready[%0d] got %b want %b", i, host_a_ready, want_rdy);
            end
            checks++;
            if (dev_a[129] !== h[0]) begin
                errors++; $display("FAIL rr_src_idx[%0d] got %b want %0d", i, dev_a[129], h);
            end
            checks++;
            if (dev_a !== mk_dev(h[0], 3'd4, 3'd3, h[0], (h == 0) ? 56'h100 : 56'h200, 64'h0)) begin
                errors++; $display("FAIL rr_payload[%0d] got %h", i, dev_a);
            end
            step();
        end
        host_a_valid = 2'b00;
    endtask

    task automatic test_burst;
        host_a[0] = mk_a(3'd0, 3'd5, 1'b0, 56'h300, 64'h1111);
        host_a[1] = mk_a(3'd4, 3'd3, 1'b1, 56'h400, 64'h0);
        host_a_valid = 2'b11;
        dev_a_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            #1;
            checks++;
            if (host_a_ready !== 2'b01) begin
                errors++; $display("FAIL burst_ready[%0d] got %b want 01", b, host_a_ready);
            end
            checks++;
            if (dev_a !== mk_dev(1'b0, 3'd0, 3'd5, 1'b0, 56'h300, 64'h1111)) begin
                errors++; $display("FAIL burst_payload[%0d] got %h", b, dev_a);
            end
            step();
        end
        host_a[0] = mk_a(3'd4, 3'd3, 1'b0, 56'h500, 64'h0);
        #1;
        checks++;
        if (host_a_ready !== 2'b10) begin
            errors++; $display("FAIL burst_next_ready got %b want 10", host_a_ready);
        end
        checks++;
        if (dev_a !== mk_dev(1'b1, 3'd4, 3'd3, 1'b1, 56'h400, 64'h0)) begin
            errors++; $display("FAIL burst_next_payload got %h", dev_a);
        end
        step();
        host_a_valid = 2'b00;
    endtask

    task automatic test_hold;
        host_a[0] = mk_a(3'd4, 3'd3, 1'b0, 56'h700, 64'h0);
        host_a[1] = mk_a(3'd4, 3'd3, 1'b1, 56'h600, 64'h0);
        dev_a_ready = 1'b0;
        host_a_valid = 2'b10;
        #1;
        checks++;
        if (dev_a_valid !== 1'b1 || host_a_ready !== 2'b00) begin
            errors++; $display("FAIL hold_c0 got valid %b ready %b want 1 00", dev_a_valid, host_a_ready);
        end
        checks++;
        if (dev_a !== mk_dev(1'b1, 3'd4, 3'd3, 1'b1, 56'h600, 64'h0)) begin
            errors++; $display("FAIL hold_c0_payload got %h", dev_a);
        end
        step();
        host_a_valid = 2'b01;
        #1;
        checks++;
        if (dev_a_valid !== 1'b0) begin
            errors++; $display("FAIL hold_owner_drop got %b want 0", dev_a_valid);
        end
        step();
        host_a_valid = 2'b11;
        #1;
        checks++;
        if (dev_a !== mk_dev(1'b1, 3'd4, 3'd3, 1'b1, 56'h600, 64'h0)) begin
            errors++; $display("FAIL hold_c2_payload got %h", dev_a);
        end
        step();
        dev_a_ready = 1'b1;
        #1;
        checks++;
        if (host_a_ready !== 2'b10) begin
            errors++; $display("FAIL hold_accept_ready got %b want 10", host_a_ready);
        end
        step();
        #1;
        checks++;
        if (host_a_ready !== 2'b01 ||
            dev_a !== mk_dev(1'b0, 3'd4, 3'd3, 1'b0, 56'h700, 64'h0)) begin
            errors++; $display("FAIL hold_next got ready %b payload %h want 01", host_a_ready, dev_a);
        end
        step();
        host_a_valid = 2'b00;
        dev_a_ready = 1'b0;
    endtask

    task automatic test_d_path;
        dev_d_valid = 1'b1;
        dev_d = {3'd1, 3'd0, 3'd3, 1'b1, 1'b1, 3'b000, 64'hCAFE};
        host_d_ready = 2'b01;
        #1;
        checks++;
        if (host_d_valid !== 2'b10 || dev_d_ready !== 1'b0) begin
            errors++; $display("FAIL d_route1 got valid %b ready %b want 10 0", host_d_valid, dev_d_ready);
        end
        checks++;
        if (host_d !== {3'd1, 3'd0, 3'd3, 1'b1, 3'b000, 64'hCAFE}) begin
            errors++; $display("FAIL d_payload got %h", host_d);
        end
        host_d_ready = 2'b11;
        #1;
        checks++;
        if (dev_d_ready !== 1'b1) begin
            errors++; $display("FAIL d_ready_raise got %b want 1", dev_d_ready);
        end
        dev_d = {3'd1, 3'd0, 3'd3, 1'b0, 1'b1, 3'b000, 64'hBEEF};
        host_d_ready = 2'b10;
        #1;
        checks++;
        if (host_d_valid !== 2'b01 || dev_d_ready !== 1'b0) begin
            errors++; $display("FAIL d_route0 got valid %b ready %b want 01 0", host_d_valid, dev_d_ready);
        end
        dev_d_valid = 1'b0;
        #1;
        checks++;
        if (host_d_valid !== 2'b00) begin
            errors++; $display("FAIL d_idle got %b want 00", host_d_valid);
        end
        host_d_ready = 2'b00;
    endtask

    task automatic test_bad_idx;
        d3_d_valid = 1'b1;
        d3_d = {3'd1, 3'd0, 3'd3, 2'd3, 1'b0, 3'b000, 64'h1};
        h3_d_ready = 3'b000;
        #1;
        checks++;
        if (d3_d_ready !== 1'b1 || h3_d_valid !== 3'b000) begin
            errors++; $display("FAIL bad_idx got ready %b valid %b want 1 000", d3_d_ready, h3_d_valid);
        end
        d3_d = {3'd1, 3'd0, 3'd3, 2'd2, 1'b0, 3'b000, 64'h1};
        h3_d_ready = 3'b100;
        #1;
        checks++;
        if (d3_d_ready !== 1'b1 || h3_d_valid !== 3'b100) begin
            errors++; $display("FAIL idx2_route got ready %b valid %b want 1 100", d3_d_ready, h3_d_valid);
        end
        h3_d_ready = 3'b011;
        #1;
        checks++;
        if (d3_d_ready !== 1'b0) begin
            errors++; $display("FAIL idx2_stall got %b want 0", d3_d_ready);
        end
        d3_d_valid = 1'b0;
    endtask

    task automatic test_reset_burst;
        host_a[0] = mk_a(3'd4, 3'd3, 1'b0, 56'h900, 64'h0);
        host_a[1] = mk_a(3'd1, 3'd5, 1'b1, 56'h800, 64'h2222);
        host_a_valid = 2'b11;
        dev_a_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            #1;
            checks++;
            if (host_a_ready !== 2'b10) begin
                errors++; $display("FAIL rstb_beat[%0d] got %b want 10", b, host_a_ready);
            end
            step();
        end
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        #1;
        checks++;
        if (host_a_ready !== 2'b01 ||
            dev_a !== mk_dev(1'b0, 3'd4, 3'd3, 1'b0, 56'h900, 64'h0)) begin
            errors++; $display("FAIL rstb_regrant got ready %b payload %h want 01", host_a_ready, dev_a);
        end
        step();
        host_a_valid = 2'b00;
        dev_a_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_hold();
        test_d_path();
        test_bad_idx();
        test_reset_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
